// File: rtl/imem_fetch_arbiter_if.sv
// Bundle of the fetch, loader and memory-side signals around the instruction
// memory arbiter. The arbiter uses the slave view; requesters and the memory
// model use the master view.
interface imem_fetch_arbiter_if #(
    parameter int ADDR_W = 5
) ();
    logic              fetch_req;
    logic [31:0]       fetch_pc;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              fetch_misalign;
    logic              fetch_busy;
    logic              load_req;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              load_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  fetch_req, fetch_pc, load_req, load_addr, load_data, mem_rdata,
        output fetch_valid, fetch_instr, fetch_misalign, fetch_busy,
               load_ack, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req, fetch_pc, load_req, load_addr, load_data, mem_rdata,
        input  fetch_valid, fetch_instr, fetch_misalign, fetch_busy,
               load_ack, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Arbiter for the single byte-wide instruction memory port. A fetch reads four
// consecutive bytes (wrapping at the top of memory) and assembles them
// big-endian; a load writes one byte. Ties between the two requesters are
// broken round-robin, with the loader winning the first tie after reset.
module imem_fetch_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_fetch_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RD3  = 3'd4,
        WR   = 3'd5
    } state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_LOAD  = 1'b1
    } grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [23:0]       instr_q, instr_d;
    logic [31:0]       fetch_instr_q, fetch_instr_d;
    logic              fetch_misalign_q, fetch_misalign_d;
    logic              fetch_valid_q, fetch_valid_d;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              load_ack;
    logic              fetch_busy;
    logic              grant_fetch;
    logic              grant_load;

    // PC bits above the memory depth are meaningless here and intentionally dropped.
    logic unused_pc_bits;
    assign unused_pc_bits = ^bus.fetch_pc[31:ADDR_W];

    // Round-robin choice between the two requesters, only meaningful in IDLE.
    always_comb begin
        grant_fetch = 1'b0;
        grant_load  = 1'b0;
        if (bus.fetch_req && bus.load_req) begin
            grant_fetch = (last_grant_q == GRANT_LOAD);
            grant_load  = (last_grant_q == GRANT_FETCH);
        end else begin
            grant_fetch = bus.fetch_req;
            grant_load  = bus.load_req;
        end
    end

    // Next-state, byte assembly and memory port drive for each phase.
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        pc_d             = pc_q;
        addr_d           = addr_q;
        data_d           = data_q;
        instr_d          = instr_q;
        fetch_instr_d    = fetch_instr_q;
        fetch_misalign_d = fetch_misalign_q;
        fetch_valid_d    = 1'b0;
        mem_addr         = '0;
        mem_we           = 1'b0;
        mem_wdata        = 8'h00;
        load_ack         = 1'b0;
        fetch_busy       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_fetch) begin
                    pc_d         = bus.fetch_pc[ADDR_W-1:0];
                    last_grant_d = GRANT_FETCH;
                    state_d      = RD0;
                end else if (grant_load) begin
                    addr_d       = bus.load_addr;
                    data_d       = bus.load_data;
                    last_grant_d = GRANT_LOAD;
                    state_d      = WR;
                end
            end
            RD0: begin
                fetch_busy     = 1'b1;
                mem_addr       = pc_q;
                instr_d[23:16] = bus.mem_rdata;
                state_d        = RD1;
            end
            RD1: begin
                fetch_busy     = 1'b1;
                mem_addr       = pc_q + ADDR_W'(1);
                instr_d[15:8]  = bus.mem_rdata;
                state_d        = RD2;
            end
            RD2: begin
                fetch_busy     = 1'b1;
                mem_addr       = pc_q + ADDR_W'(2);
                instr_d[7:0]   = bus.mem_rdata;
                state_d        = RD3;
            end
            RD3: begin
                fetch_busy       = 1'b1;
                mem_addr         = pc_q + ADDR_W'(3);
                fetch_instr_d    = {instr_q, bus.mem_rdata};
                fetch_misalign_d = (pc_q[1:0] != 2'b00);
                fetch_valid_d    = 1'b1;
                state_d          = IDLE;
            end
            WR: begin
                mem_addr  = addr_q;
                mem_wdata = data_q;
                mem_we    = 1'b1;
                load_ack  = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            last_grant_q     <= GRANT_FETCH;
            pc_q             <= '0;
            addr_q           <= '0;
            data_q           <= 8'h00;
            instr_q          <= 24'h0;
            fetch_instr_q    <= 32'h0;
            fetch_misalign_q <= 1'b0;
            fetch_valid_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            pc_q             <= pc_d;
            addr_q           <= addr_d;
            data_q           <= data_d;
            instr_q          <= instr_d;
            fetch_instr_q    <= fetch_instr_d;
            fetch_misalign_q <= fetch_misalign_d;
            fetch_valid_q    <= fetch_valid_d;
        end
    end

    assign bus.fetch_valid    = fetch_valid_q;
    assign bus.fetch_instr    = fetch_instr_q;
    assign bus.fetch_misalign = fetch_misalign_q;
    assign bus.fetch_busy     = fetch_busy;
    assign bus.load_ack       = load_ack;
    assign bus.mem_addr       = mem_addr;
    assign bus.mem_we         = mem_we;
    assign bus.mem_wdata      = mem_wdata;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Self-checking bench for the instruction memory arbiter: a byte memory model
// sits on the memory port, and expected fetch words come from a separate
// reference image updated whenever the bench issues a load.
module tb_imem_fetch_arbiter;

    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;

    imem_fetch_arbiter_if #(.ADDR_W(AW)) bus ();

    imem_fetch_arbiter #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem     [DEPTH];
    logic [7:0] ref_mem [DEPTH];

    int checks = 0;
    int passed = 0;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory with combinational read and clocked write.
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] pc);
        int b;
        b = int'(pc % DEPTH);
        return {ref_mem[b % DEPTH], ref_mem[(b + 1) % DEPTH],
                ref_mem[(b + 2) % DEPTH], ref_mem[(b + 3) % DEPTH]};
    endfunction

    function automatic logic [4*AW-1:0] ref_addrs(input logic [31:0] pc);
        logic [4*AW-1:0] r;
        int b;
        b = int'(pc % DEPTH);
        for (int k = 0; k < 4; k++) r[(3-k)*AW +: AW] = AW'((b + k) % DEPTH);
        return r;
    endfunction

    // Drives one load from IDLE and returns in the following IDLE cycle.
    task automatic run_load(input logic [AW-1:0] addr, input logic [7:0] data,
                            output int lat, output logic [AW+8:0] seen);
        lat  = -1;
        seen = '0;
        bus.load_addr = addr;
        bus.load_data = data;
        bus.load_req  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.load_ack) begin
                lat  = c;
                seen = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
                break;
            end
        end
        bus.load_req = 1'b0;
        ref_mem[addr] = data;
        tick();
    endtask

    // Drives one fetch from IDLE and returns in its valid cycle.
    task automatic run_fetch(input logic [31:0] pc, output logic [31:0] instr,
                             output logic mis, output int lat,
                             output logic [4*AW-1:0] addrs, output logic we_seen);
        int k;
        k = 0;
        lat = -1;
        instr = '0;
        mis = 1'b0;
        addrs = '0;
        we_seen = 1'b0;
        bus.fetch_pc  = pc;
        bus.fetch_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.mem_we) we_seen = 1'b1;
            if (bus.fetch_busy && k < 4) begin
                addrs[(3-k)*AW +: AW] = bus.mem_addr;
                k++;
            end
            if (bus.fetch_valid) begin
                lat   = c;
                instr = bus.fetch_instr;
                mis   = bus.fetch_misalign;
                break;
            end
        end
        bus.fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW+75:0] got;
        rst_n = 1'b0;
        tick();
        tick();
        got = {bus.fetch_valid, bus.fetch_instr, bus.fetch_misalign, bus.fetch_busy,
               bus.load_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata, 32'h0};
        checks++;
        if (got !== '0) $display("[TB] FAIL reset_outputs: got %h expected 0", got);
        else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_fetch();
        logic [7:0] bytes [4];
        int lat;
        logic [AW+8:0] seen;
        logic [31:0] instr;
        logic mis, we;
        logic [4*AW-1:0] addrs;
        bytes[0] = 8'h00; bytes[1] = 8'h23; bytes[2] = 8'h50; bytes[3] = 8'h22;
        for (int i = 0; i < 4; i++) begin
            run_load(AW'(4 + i), bytes[i], lat, seen);
            checks++;
            if (lat !== 1 || seen !== {1'b1, AW'(4 + i), bytes[i]})
                $display("[TB] FAIL load_handshake: lat %0d port %h expected lat 1 port %h",
                         lat, seen, {1'b1, AW'(4 + i), bytes[i]});
            else passed++;
        end
        run_fetch(32'd4, instr, mis, lat, addrs, we);
        checks++;
        if (lat !== 5) $display("[TB] FAIL fetch_latency: got %0d expected 5", lat);
        else passed++;
        checks++;
        if (addrs !== {5'd4, 5'd5, 5'd6, 5'd7})
            $display("[TB] FAIL fetch_addrs: got %h expected %h", addrs, {5'd4, 5'd5, 5'd6, 5'd7});
        else passed++;
        checks++;
        if (instr !== 32'h00235022 || mis !== 1'b0 || we !== 1'b0)
            $display("[TB] FAIL fetch_word: got %h mis %b we %b expected 00235022 mis 0 we 0",
                     instr, mis, we);
        else passed++;
    endtask

    task automatic test_random();
        int lat;
        logic [AW+8:0] seen;
        logic [31:0] instr, pc;
        logic mis, we;
        logic [4*AW-1:0] addrs;
        logic [AW-1:0] a;
        logic [7:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = 8'($urandom());
            run_load(AW'(i), d, lat, seen);
            checks++;
            if (lat !== 1 || seen !== {1'b1, AW'(i), d})
                $display("[TB] FAIL preload: lat %0d port %h expected lat 1 port %h",
                         lat, seen, {1'b1, AW'(i), d});
            else passed++;
        end
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = AW'($urandom());
                d = 8'($urandom());
                run_load(a, d, lat, seen);
                checks++;
                if (lat !== 1 || seen !== {1'b1, a, d})
                    $display("[TB] FAIL rand_load: lat %0d port %h expected lat 1 port %h",
                             lat, seen, {1'b1, a, d});
                else passed++;
            end else begin
                pc = $urandom();
                run_fetch(pc, instr, mis, lat, addrs, we);
                checks++;
                if (lat !== 5 || instr !== ref_word(pc) || mis !== (pc[1:0] != 2'b00) ||
                    addrs !== ref_addrs(pc) || we !== 1'b0)
                    $display("[TB] FAIL rand_fetch pc %h: lat %0d word %h mis %b addrs %h expected lat 5 word %h mis %b addrs %h",
                             pc, lat, instr, mis, addrs, ref_word(pc), pc[1:0] != 2'b00, ref_addrs(pc));
                else passed++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] b30, b31, b0, b1;
        int lat;
        logic [AW+8:0] seen;
        logic [31:0] instr;
        logic mis, we;
        logic [4*AW-1:0] addrs;
        b30 = 8'($urandom()); b31 = 8'($urandom());
        b0  = 8'($urandom()); b1  = 8'($urandom());
        run_load(5'd30, b30, lat, seen);
        run_load(5'd31, b31, lat, seen);
        run_load(5'd0,  b0,  lat, seen);
        run_load(5'd1,  b1,  lat, seen);
        run_fetch(32'd30, instr, mis, lat, addrs, we);
        checks++;
        if (addrs !== {5'd30, 5'd31, 5'd0, 5'd1})
            $display("[TB] FAIL wrap_addrs: got %h expected %h", addrs, {5'd30, 5'd31, 5'd0, 5'd1});
        else passed++;
        checks++;
        if (instr !== {b30, b31, b0, b1} || mis !== 1'b1)
            $display("[TB] FAIL wrap_word: got %h mis %b expected %h mis 1",
                     instr, mis, {b30, b31, b0, b1});
        else passed++;
    endtask

    task automatic test_arbitration();
        logic [22:0] exp_ack, exp_busy, exp_valid, drv_fr, drv_lr;
        logic [2:0] got, want;
        exp_ack   = 23'h408102;
        exp_busy  = 23'h1E3C78;
        exp_valid = 23'h204080;
        drv_fr    = 23'h1FBFFF;
        drv_lr    = 23'h3FC081;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.fetch_pc  = 32'd0;
        bus.load_addr = 5'd20;
        bus.load_data = 8'h5A;
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) begin
                tick();
                got  = {bus.load_ack, bus.fetch_busy, bus.fetch_valid};
                want = {exp_ack[c], exp_busy[c], exp_valid[c]};
                checks++;
                if (got !== want)
                    $display("[TB] FAIL arb_cycle%0d: ack/busy/valid %b expected %b", c, got, want);
                else passed++;
            end
            bus.fetch_req = drv_fr[c];
            bus.load_req  = drv_lr[c];
        end
        ref_mem[20] = 8'h5A;
        tick();
    endtask

    task automatic test_load_during_fetch();
        logic [7:0] d;
        logic we_any;
        for (int v = 0; v < 2; v++) begin
            d = 8'($urandom());
            we_any = 1'b0;
            bus.fetch_pc  = 32'd8;
            bus.fetch_req = 1'b1;
            for (int c = 1; c <= 6; c++) begin
                tick();
                if (c == 2) begin
                    bus.load_addr = 5'd17;
                    bus.load_data = d;
                    bus.load_req  = 1'b1;
                end
                if (c >= 2 && c <= 4 && (bus.mem_we || bus.load_ack)) we_any = 1'b1;
                if (c == 5) begin
                    checks++;
                    if (bus.fetch_valid !== 1'b1 || bus.fetch_instr !== ref_word(32'd8))
                        $display("[TB] FAIL lf_fetch v%0d: valid %b word %h expected valid 1 word %h",
                                 v, bus.fetch_valid, bus.fetch_instr, ref_word(32'd8));
                    else passed++;
                    bus.fetch_req = (v == 1);
                end
                if (c == 6) begin
                    checks++;
                    if (bus.load_ack !== 1'b1 || bus.mem_we !== 1'b1 || bus.fetch_busy !== 1'b0)
                        $display("[TB] FAIL lf_ack v%0d: ack %b we %b busy %b expected 1 1 0",
                                 v, bus.load_ack, bus.mem_we, bus.fetch_busy);
                    else passed++;
                    bus.fetch_req = 1'b0;
                    bus.load_req  = 1'b0;
                end
            end
            checks++;
            if (we_any !== 1'b0) $display("[TB] FAIL lf_no_overlap v%0d: got write 1 expected 0", v);
            else passed++;
            ref_mem[17] = d;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] got, want;
        bus.fetch_pc  = 32'd8;
        bus.fetch_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            got  = {bus.fetch_busy, bus.fetch_valid};
            want = {(c % 5) != 0, (c % 5) == 0};
            checks++;
            if (got !== want)
                $display("[TB] FAIL b2b_cycle%0d: busy/valid %b expected %b", c, got, want);
            else passed++;
            if (c == 5) begin
                checks++;
                if (bus.fetch_instr !== ref_word(32'd8))
                    $display("[TB] FAIL b2b_word8: got %h expected %h", bus.fetch_instr, ref_word(32'd8));
                else passed++;
                bus.fetch_pc = 32'd12;
            end
            if (c == 10) begin
                checks++;
                if (bus.fetch_instr !== ref_word(32'd12) || bus.fetch_misalign !== 1'b0)
                    $display("[TB] FAIL b2b_word12: got %h mis %b expected %h mis 0",
                             bus.fetch_instr, bus.fetch_misalign, ref_word(32'd12));
                else passed++;
                bus.fetch_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [35:0] got;
        int pulses;
        bus.fetch_pc  = $urandom();
        bus.fetch_req = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.fetch_req = 1'b0;
        got = {bus.fetch_valid, bus.fetch_instr, bus.fetch_busy, bus.mem_we, bus.load_ack};
        checks++;
        if (got !== '0) $display("[TB] FAIL mid_reset_outputs: got %h expected 0", got);
        else passed++;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.fetch_valid || bus.fetch_busy) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("[TB] FAIL mid_reset_no_pulse: got %0d expected 0", pulses);
        else passed++;
    endtask

    // Test sequence.
    initial begin
        rst_n         = 1'b0;
        bus.fetch_req = 1'b0;
        bus.fetch_pc  = 32'h0;
        bus.load_req  = 1'b0;
        bus.load_addr = '0;
        bus.load_data = 8'h00;
        test_reset();
        test_load_fetch();
        test_random();
        test_wrap();
        test_arbitration();
        test_load_during_fetch();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
